// File: rtl/regfile_write_queue.sv
// In-order write buffer between result producers and the register-file write port.
// Optional build macro WBQ_R0_DROP_EN: accepted writes to register 0 are discarded instead of queued.
module regfile_write_queue #(
    parameter int DataSize = 32,
    parameter int AddrSize = 5,
    parameter int Depth    = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AddrSize-1:0]      in_address,
    input  logic [DataSize-1:0]      in_data,
    input  logic                     enable_fetch,
    output logic                     enable_writeback,
    output logic [AddrSize-1:0]      write_address,
    output logic [DataSize-1:0]      write_data,
    input  logic [AddrSize-1:0]      query_address1,
    input  logic [AddrSize-1:0]      query_address2,
    output logic                     pending1,
    output logic                     pending2,
    output logic [$clog2(Depth):0]   count
);

    localparam int PtrW = $clog2(Depth);
    localparam int CntW = PtrW + 1;

    logic [AddrSize-1:0] addr_mem_q [Depth];
    logic [DataSize-1:0] data_mem_q [Depth];
    logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CntW-1:0]     count_q, count_d;

    logic full, empty, push, store, pop;
    logic [Depth-1:0] occupied, hit1, hit2;

    assign full  = (count_q == CntW'(Depth));
    assign empty = (count_q == '0);

    // Ready is derived from occupancy only, so a same-cycle pop never frees a slot early.
    assign in_ready         = !full;
    assign enable_writeback = !empty && !enable_fetch;
    assign push             = in_valid && in_ready;
    assign pop              = enable_writeback;

`ifdef WBQ_R0_DROP_EN
    assign store = push && (in_address != '0);
`else
    assign store = push;
`endif

    assign write_address = addr_mem_q[rd_ptr_q];
    assign write_data    = data_mem_q[rd_ptr_q];
    assign count         = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (store) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (store && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !store) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < Depth; gi++) begin : g_entry
            logic [PtrW-1:0] offset;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    addr_mem_q[gi] <= '0;
                    data_mem_q[gi] <= '0;
                end else if (store && (wr_ptr_q == PtrW'(gi))) begin
                    addr_mem_q[gi] <= in_address;
                    data_mem_q[gi] <= in_data;
                end
            end

            // An entry is live when its distance from the head is below the occupancy.
            assign offset       = PtrW'(gi) - rd_ptr_q;
            assign occupied[gi] = (CntW'(offset) < count_q);
            assign hit1[gi]     = occupied[gi] && (addr_mem_q[gi] == query_address1);
            assign hit2[gi]     = occupied[gi] && (addr_mem_q[gi] == query_address2);
        end
    endgenerate

    assign pending1 = |hit1;
    assign pending2 = |hit2;

endmodule

// File: doc/regfile_write_queue.md
# regfile_write_queue

Buffers register-write results from the execute/load side and drains them into the register file's write port in program order. The register file gives its fetch access priority over writeback, so this block holds each write until a cycle with no fetch. It also reports whether a register still has a write pending, so issue logic can stall on RAW hazards. The block sits between the result producers and the register file's `write_address` / `write_data` / `enable_writeback` inputs.

## Interface
- `DataSize`, 32, width of register data
- `AddrSize`, 5, width of register address
- `Depth`, 4, queue entries; power of two, at least 2

- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; clears the queue
- `in_valid`  in  1  producer offers a write this cycle
- `in_ready`  out  1  queue can accept; equals `!full`
- `in_address`  in  AddrSize  destination register
- `in_data`  in  DataSize  value to write
- `enable_fetch`  in  1  the pipeline is fetching from the register file this cycle
- `enable_writeback`  out  1  write strobe to the register file
- `write_address`  out  AddrSize  head entry address
- `write_data`  out  DataSize  head entry data
- `query_address1`  in  AddrSize  first hazard-query register
- `query_address2`  in  AddrSize  second hazard-query register
- `pending1`  out  1  a queued write targets `query_address1`
- `pending2`  out  1  a queued write targets `query_address2`
- `count`  out  $clog2(Depth)+1  current occupancy

## Operation
- Circular buffer with read pointer, write pointer and occupancy counter.
- **Push:** occurs when `in_valid && in_ready` at a clock edge. Stores `{in_address, in_data}` at the write pointer and advances the pointer, wrapping modulo `Depth`.
- **Drain:** `enable_writeback = !empty && !enable_fetch`, combinational.
  - `write_address` and `write_data` always show the head entry.
  - A pop occurs at every edge where `enable_writeback` is high; the read pointer advances and wraps.
- **Fetch conflict:** while `enable_fetch` is high the head is held and never popped, so no write is lost to the register file's fetch priority.
- **Push and pop in the same cycle:** both happen and `count` is unchanged.
- **When full:** `in_ready` stays low even if a pop occurs that cycle. `in_ready` has no combinational path from `enable_fetch`.
- **When empty:** `enable_writeback` is 0. A pushed entry is visible at the head the next cycle; there is no bypass.
- **Hazard flags:** `pendingN` is the OR over all occupied entries of (`entry.address == query_addressN`). It is combinational and counts the head entry until its pop edge.
- **Ordering:** strict FIFO. Repeated writes to the same register land in program order, so the last write wins.

## Timing
- Reset, asynchronous and immediate: pointers = 0, `count` = 0, all storage = 0.
  - Resulting outputs: `enable_writeback` = 0, `write_address` = 0, `write_data` = 0, `in_ready` = 1, `pending1` = `pending2` = 0.
- Reset asserted mid-operation discards all queued writes. The first push after reset deasserts is accepted at the next edge.
- Push-to-strobe latency is 1 cycle minimum. Each cycle with `enable_fetch` high adds one cycle.
- Throughput is one write per cycle when `enable_fetch` is low.
- `count` updates on the clock edge: +1 on push only, −1 on pop only.

## Configuration
- **`WBQ_R0_DROP_EN` defined:** a push with `in_address == 0` is accepted (`in_ready` rules are unchanged) but not stored. `count` does not change, and `pending` never asserts for register 0.
- **Not defined:** register-0 writes are queued and drained like any other register.

## Test plan
- **Push then drain:** push (3, 0xDEADBEEF) with `enable_fetch` = 0 → next cycle `enable_writeback` = 1, `write_address` = 3, `write_data` = 0xDEADBEEF; the cycle after, `count` = 0.
- **Fetch hold:** push (7, 0x11) with `enable_fetch` held high for 3 cycles → `enable_writeback` = 0, head = (7, 0x11) and `pending` for query 7 = 1 throughout; the strobe occurs the cycle `enable_fetch` drops.
- **Fill and wrap:** hold `enable_fetch` = 1 and push 4 entries (1..4, 0xA1..0xA4) → `count` = 4 and `in_ready` = 0; a fifth offer is not taken. Release `enable_fetch` → drains 1, 2, 3, 4 in order. Push 2 more → pointers wrap and the order is still correct.
- **Simultaneous push and pop:** with `count` = 2 and `enable_fetch` = 0, push every cycle for 5 cycles → `count` stays 2 and the writes appear in order.
- **Reset mid-queue:** with 3 entries queued, pulse `reset` between edges → `count` = 0, `enable_writeback` = 0 and `pending` = 0 immediately.
- **R0 handling:** push (0, 0x55) → with `WBQ_R0_DROP_EN` defined, `count` stays 0 and there is no strobe; without it, a strobe with `write_address` = 0 follows.
